lsu_burst_read_arbiter: RTL and testbench
=========================================

Name: lsu_burst_read_arbiter

Overview:
- Shares one Avalon-MM burst read master port among NUM_PORTS streaming prefetch read units.
- Arbitrates burst read commands round-robin and holds the grant stable while the memory asserts waitrequest.
- Records the owner of each accepted burst in order, then routes readdatavalid beats back to that owner.
- Sits between the prefetch LSUs' avm_* ports and the global memory interconnect.

Parameters:
- NUM_PORTS, 2, number of requesting read units (2..8)
- AWIDTH, 32, byte address width
- MWIDTH_BYTES, 32, memory word width in bytes
- BURSTCOUNT_WIDTH, 6, burstcount field width
- MAX_OUTSTANDING, 8, maximum accepted bursts awaiting data (power of 2)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- i_avm_read  in  NUM_PORTS  per-port read request
- i_avm_address  in  NUM_PORTS*AWIDTH  per-port address, port p at [p*AWIDTH +: AWIDTH]
- i_avm_burstcount  in  NUM_PORTS*BURSTCOUNT_WIDTH  per-port burstcount
- i_avm_byteenable  in  NUM_PORTS*MWIDTH_BYTES  per-port byteenable
- o_avm_waitrequest  out  NUM_PORTS  per-port waitrequest
- o_avm_readdata  out  8*MWIDTH_BYTES  read data, broadcast to all ports
- o_avm_readdatavalid  out  NUM_PORTS  per-port data valid
- avm_read  out  1  downstream read
- avm_address  out  AWIDTH  downstream address
- avm_burstcount  out  BURSTCOUNT_WIDTH  downstream burstcount
- avm_byteenable  out  MWIDTH_BYTES  downstream byteenable
- avm_waitrequest  in  1  downstream waitrequest
- avm_readdata  in  8*MWIDTH_BYTES  downstream read data
- avm_readdatavalid  in  1  downstream data valid
- o_active  out  1  high while any burst is outstanding
- o_error  out  1  sticky: readdatavalid received with no outstanding burst

Behaviour:
Reset
- Asynchronous, active-high; clock clk.
- Resets: RR pointer to 0, lock flag to 0, tracker empty, beat counter to 0, o_error to 0.
- Outputs during and after reset: avm_read=0, o_avm_readdatavalid=0, o_active=0, o_error=0.
- o_avm_waitrequest = all ones while the tracker is full, else per the grant rules below.

Command arbitration (combinational, zero latency)
- Grant source:
  - If locked, grant = lock_port.
  - Otherwise, grant = first port with i_avm_read set, searching from rr_ptr upward with wrap.
- avm_read = i_avm_read[grant] & !tracker_full.
- avm_address, avm_burstcount and avm_byteenable are muxed from the grant port.
- o_avm_waitrequest[p] = 0 only when p == grant and avm_read=1 and avm_waitrequest=0; otherwise 1.
- Accept = avm_read & !avm_waitrequest.
- On accept:
  - push {grant, burstcount} into the tracker;
  - rr_ptr <= (grant+1) mod NUM_PORTS;
  - lock <= 0.
- If avm_read & avm_waitrequest: lock <= 1 and lock_port <= grant. The grant may not change until accept.
- A locked port that drops i_avm_read (protocol violation) clears the lock on the next cycle.
- Tracker full: avm_read is forced low. A pop in the same cycle does not enable a push (push is judged on registered full).

Response routing
- Tracker is a FIFO of {port id, burstcount}, depth MAX_OUTSTANDING.
- o_avm_readdata = avm_readdata, unregistered.
- o_avm_readdatavalid[p] = avm_readdatavalid & !empty & (head.port == p).
- Beat counter (BURSTCOUNT_WIDTH bits) increments on each valid beat.
- On the beat where counter == head.burstcount-1: pop the head and clear the counter.
- burstcount 0 is treated as 1.
- readdatavalid while empty: drop the beat, set o_error (sticky until reset).
- Simultaneous push and pop is allowed when not full; occupancy stays unchanged.
- o_active = !empty.
- Reset mid-burst: the tracker is cleared and late beats set o_error. Upstream units must be reset together with the arbiter.

Decomposition:
- Package lsu_arb_pkg:
  - PORT_ID_WIDTH = $clog2(NUM_PORTS), minimum 1;
  - tracker entry struct {port_id, burstcount};
  - round-robin priority-select function.
- Sub-module lsu_arb_resp_tracker:
  - contains the FIFO plus beat counter;
  - inputs: push, push_entry, readdatavalid;
  - outputs: full, empty, head_port, pop, error.

Test Plan:
1. Port0 alone issues burstcount=4 at 0x1000, no waitrequest → accepted in 1 cycle; 4 beats all on o_avm_readdatavalid[0]; o_active falls after beat 4.
2. Ports 0 and 1 request continuously with burstcount=2, rr_ptr=0 → grants alternate 0,1,0,1; data beats route in the same order with 2 beats each.
3. Port1 granted, avm_waitrequest high 3 cycles, port0 raises read in cycle 2 → address/burstcount held at port1 values for all 3 cycles; port1 accepted, port0 next.
4. MAX_OUTSTANDING=8 bursts accepted, no data returned → 9th request sees waitrequest; after the first burst's last beat pops, the 9th is accepted next cycle.
5. readdatavalid pulse with empty tracker → no o_avm_readdatavalid bit set, o_error=1 and held; reset clears o_error to 0.
6. Reset asserted mid-burst (2 of 4 beats delivered) → outputs go to reset values immediately; next request is granted to port 0.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types and helpers for the LSU burst read arbiter.
// Entry fields are sized for the largest supported configuration.
package lsu_arb_pkg;

    localparam int unsigned MAX_PORTS     = 8;
    localparam int unsigned PORT_ID_MAX_W = 3;
    localparam int unsigned BC_MAX_W      = 16;

    typedef struct packed {
        logic [PORT_ID_MAX_W-1:0] port_id;
        logic [BC_MAX_W-1:0]      burstcount;
    } trk_entry_t;

    // Port id width for n requesters, never narrower than one bit.
    function automatic int unsigned port_id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set request at or above ptr, wrapping at n; returns ptr if none are set.
    function automatic logic [PORT_ID_MAX_W-1:0] rr_select(
        input logic [MAX_PORTS-1:0]     req,
        input logic [PORT_ID_MAX_W-1:0] ptr,
        input int unsigned              n
    );
        logic [PORT_ID_MAX_W-1:0] sel;
        logic                     found;
        int unsigned              idx;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            idx = (32'(ptr) + i) % n;
            if ((i < n) && !found && req[idx[PORT_ID_MAX_W-1:0]]) begin
                sel   = idx[PORT_ID_MAX_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/lsu_arb_resp_tracker.sv
// In-order record of accepted bursts; counts returning beats and retires
// the head burst on its last beat.
module lsu_arb_resp_tracker
    import lsu_arb_pkg::*;
#(
    parameter int unsigned DEPTH            = 8,
    parameter int unsigned BURSTCOUNT_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  trk_entry_t               push_entry_i,
    input  logic                     readdatavalid_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [PORT_ID_MAX_W-1:0] head_port_o,
    output logic                     error_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    trk_entry_t                  mem_q [DEPTH];
    trk_entry_t                  head;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 count_q, count_d;
    logic [BURSTCOUNT_WIDTH-1:0] beat_q, beat_d;
    logic                        error_q, error_d;
    logic                        do_push, beat_valid, last_beat, pop;

    assign head        = mem_q[rd_ptr_q];
    assign full_o      = (count_q == FULL_COUNT);
    assign empty_o     = (count_q == '0);
    assign head_port_o = head.port_id;
    assign error_o     = error_q;

    assign do_push    = push_i & ~full_o;
    assign beat_valid = readdatavalid_i & ~empty_o;
    // A burstcount of 0 retires on its first beat, same as 1.
    assign last_beat  = (head.burstcount <= BC_MAX_W'(1)) ||
                        (BC_MAX_W'(beat_q) == head.burstcount - BC_MAX_W'(1));
    assign pop        = beat_valid & last_beat;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        error_d  = error_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (pop)             beat_d = '0;
        else if (beat_valid) beat_d = beat_q + 1'b1;
        if (readdatavalid_i && empty_o) error_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            error_q  <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

endmodule

// File: rtl/lsu_burst_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM burst read master among several
// prefetch LSUs; read beats are steered back to the burst owner in order.
module lsu_burst_read_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS        = 2,
    parameter int unsigned AWIDTH           = 32,
    parameter int unsigned MWIDTH_BYTES     = 32,
    parameter int unsigned BURSTCOUNT_WIDTH = 6,
    parameter int unsigned MAX_OUTSTANDING  = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_PORTS-1:0]                  i_avm_read,
    input  logic [NUM_PORTS*AWIDTH-1:0]           i_avm_address,
    input  logic [NUM_PORTS*BURSTCOUNT_WIDTH-1:0] i_avm_burstcount,
    input  logic [NUM_PORTS*MWIDTH_BYTES-1:0]     i_avm_byteenable,
    output logic [NUM_PORTS-1:0]                  o_avm_waitrequest,
    output logic [8*MWIDTH_BYTES-1:0]             o_avm_readdata,
    output logic [NUM_PORTS-1:0]                  o_avm_readdatavalid,
    output logic                                  avm_read,
    output logic [AWIDTH-1:0]                     avm_address,
    output logic [BURSTCOUNT_WIDTH-1:0]           avm_burstcount,
    output logic [MWIDTH_BYTES-1:0]               avm_byteenable,
    input  logic                                  avm_waitrequest,
    input  logic [8*MWIDTH_BYTES-1:0]             avm_readdata,
    input  logic                                  avm_readdatavalid,
    output logic                                  o_active,
    output logic                                  o_error
);

    localparam int unsigned PORT_ID_WIDTH = port_id_width(NUM_PORTS);

    logic [PORT_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d, lock_port_q, lock_port_d, grant;
    logic                     lock_q, lock_d, accept;
    logic                     trk_full, trk_empty;
    logic [PORT_ID_MAX_W-1:0] trk_head_port;
    trk_entry_t               push_entry;

    // While the memory stalls a command, the grant stays pinned to that port.
    assign grant = lock_q ? lock_port_q
                 : PORT_ID_WIDTH'(rr_select(MAX_PORTS'(i_avm_read),
                                            PORT_ID_MAX_W'(rr_ptr_q), NUM_PORTS));

    assign avm_read       = i_avm_read[grant] & ~trk_full & ~reset;
    assign avm_address    = i_avm_address[grant*AWIDTH +: AWIDTH];
    assign avm_burstcount = i_avm_burstcount[grant*BURSTCOUNT_WIDTH +: BURSTCOUNT_WIDTH];
    assign avm_byteenable = i_avm_byteenable[grant*MWIDTH_BYTES +: MWIDTH_BYTES];
    assign accept         = avm_read & ~avm_waitrequest;

    assign push_entry.port_id    = PORT_ID_MAX_W'(grant);
    assign push_entry.burstcount = BC_MAX_W'(avm_burstcount);

    assign o_avm_readdata = avm_readdata;
    assign o_active       = ~trk_empty;

    always_comb begin
        o_avm_waitrequest = '1;
        if (accept) o_avm_waitrequest[grant] = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            o_avm_readdatavalid[p] = avm_readdatavalid & ~trk_empty &
                                     (trk_head_port == PORT_ID_MAX_W'(p));
        end
    end

    // A locked port that withdraws its read falls through to lock_d = 0.
    always_comb begin
        lock_d      = 1'b0;
        lock_port_d = lock_port_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant == PORT_ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
        end else if (avm_read) begin
            lock_d      = 1'b1;
            lock_port_d = grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
        end
    end

    lsu_arb_resp_tracker #(
        .DEPTH            (MAX_OUTSTANDING),
        .BURSTCOUNT_WIDTH (BURSTCOUNT_WIDTH)
    ) u_tracker (
        .clk             (clk),
        .reset           (reset),
        .push_i          (accept),
        .push_entry_i    (push_entry),
        .readdatavalid_i (avm_readdatavalid),
        .full_o          (trk_full),
        .empty_o         (trk_empty),
        .head_port_o     (trk_head_port),
        .error_o         (o_error)
    );

endmodule

// File: tb/tb_lsu_burst_read_arbiter.sv
// Directed bench for lsu_burst_read_arbiter with a queue-based reference model
// checked every cycle plus hand-computed expectations per scenario.
module tb_lsu_burst_read_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int MB = 32;
    localparam int BW = 6;
    localparam int MO = 8;
    localparam int DW = 8 * MB;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NP-1:0]    i_avm_read = '0;
    logic [NP*AW-1:0] i_avm_address = '0;
    logic [NP*BW-1:0] i_avm_burstcount = '0;
    logic [NP*MB-1:0] i_avm_byteenable = '0;
    logic [NP-1:0]    o_avm_waitrequest;
    logic [DW-1:0]    o_avm_readdata;
    logic [NP-1:0]    o_avm_readdatavalid;
    logic             avm_read;
    logic [AW-1:0]    avm_address;
    logic [BW-1:0]    avm_burstcount;
    logic [MB-1:0]    avm_byteenable;
    logic             avm_waitrequest = 1'b0;
    logic [DW-1:0]    avm_readdata = '0;
    logic             avm_readdatavalid = 1'b0;
    logic             o_active;
    logic             o_error;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: bursts outstanding as (owner, beats remaining).
    int m_rr;
    bit m_locked;
    int m_lock_port;
    bit m_err;
    int q_port[$];
    int q_rem[$];

    lsu_burst_read_arbiter #(
        .NUM_PORTS        (NP),
        .AWIDTH           (AW),
        .MWIDTH_BYTES     (MB),
        .BURSTCOUNT_WIDTH (BW),
        .MAX_OUTSTANDING  (MO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_avm_read          (i_avm_read),
        .i_avm_address       (i_avm_address),
        .i_avm_burstcount    (i_avm_burstcount),
        .i_avm_byteenable    (i_avm_byteenable),
        .o_avm_waitrequest   (o_avm_waitrequest),
        .o_avm_readdata      (o_avm_readdata),
        .o_avm_readdatavalid (o_avm_readdatavalid),
        .avm_read            (avm_read),
        .avm_address         (avm_address),
        .avm_burstcount      (avm_burstcount),
        .avm_byteenable      (avm_byteenable),
        .avm_waitrequest     (avm_waitrequest),
        .avm_readdata        (avm_readdata),
        .avm_readdatavalid   (avm_readdatavalid),
        .o_active            (o_active),
        .o_error             (o_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] addr, input logic [BW-1:0] bc);
        i_avm_address[p*AW +: AW]    = addr;
        i_avm_burstcount[p*BW +: BW] = bc;
        i_avm_byteenable[p*MB +: MB] = 32'hF0F0_0000 | 32'(p + 1);
        i_avm_read[p]                = 1'b1;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        i_avm_read        = '0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Every-cycle comparison against the model, then advance the model.
    always @(negedge clk) begin
        int            g;
        bit            found;
        bit            full;
        bit            e_read;
        logic [NP-1:0] e_wait;
        logic [NP-1:0] e_rdv;
        if (reset) begin
            m_rr = 0; m_locked = 0; m_lock_port = 0; m_err = 0;
            q_port.delete();
            q_rem.delete();
            chk("rst_avm_read", avm_read, 0);
            chk("rst_rdv", o_avm_readdatavalid, 0);
            chk("rst_active", o_active, 0);
            chk("rst_error", o_error, 0);
            chk("rst_wait", o_avm_waitrequest, {NP{1'b1}});
        end else begin
            g = m_rr;
            if (m_locked) g = m_lock_port;
            else begin
                found = 0;
                for (int k = 0; k < NP; k++) begin
                    if (!found && i_avm_read[(m_rr + k) % NP]) begin
                        g = (m_rr + k) % NP;
                        found = 1;
                    end
                end
            end
            full   = (q_port.size() == MO);
            e_read = i_avm_read[g] && !full;
            e_wait = '1;
            if (e_read && !avm_waitrequest) e_wait[g] = 1'b0;
            e_rdv = '0;
            if (avm_readdatavalid && q_port.size() > 0) e_rdv[q_port[0]] = 1'b1;

            chk("m_avm_read", avm_read, e_read);
            chk("m_wait", o_avm_waitrequest, e_wait);
            chk("m_rdv", o_avm_readdatavalid, e_rdv);
            chk("m_readdata", o_avm_readdata, avm_readdata);
            chk("m_active", o_active, q_port.size() > 0);
            chk("m_error", o_error, m_err);
            if (e_read) begin
                chk("m_addr", avm_address, i_avm_address[g*AW +: AW]);
                chk("m_bc", avm_burstcount, i_avm_burstcount[g*BW +: BW]);
                chk("m_be", avm_byteenable, i_avm_byteenable[g*MB +: MB]);
            end

            if (avm_readdatavalid) begin
                if (q_port.size() == 0) m_err = 1;
                else begin
                    q_rem[0] = q_rem[0] - 1;
                    if (q_rem[0] == 0) begin
                        void'(q_port.pop_front());
                        void'(q_rem.pop_front());
                    end
                end
            end
            if (e_read && !avm_waitrequest) begin
                q_port.push_back(g);
                q_rem.push_back(i_avm_burstcount[g*BW +: BW] == 0 ? 1
                                : int'(i_avm_burstcount[g*BW +: BW]));
                m_rr = (g + 1) % NP;
                m_locked = 0;
            end else if (e_read) begin
                m_locked = 1;
                m_lock_port = g;
            end else begin
                m_locked = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [NP-1:0] t2_wait [4];
        logic [NP-1:0] t2_rdv  [8];
        logic [NP-1:0] t3_rdv  [4];
        t2_wait = '{2'b10, 2'b01, 2'b10, 2'b01};
        t2_rdv  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        t3_rdv  = '{2'b10, 2'b10, 2'b10, 2'b01};

        // 1: single port, burst of 4
        do_reset();
        set_port(0, 32'h1000, 6'd4);
        @(negedge clk);
        chk("t1_read", avm_read, 1);
        chk("t1_addr", avm_address, 32'h1000);
        chk("t1_wait", o_avm_waitrequest, 2'b10);
        step();
        i_avm_read = '0;
        @(negedge clk);
        chk("t1_active", o_active, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            avm_readdatavalid = 1'b1;
            avm_readdata = {8{32'hD000_0000 + 32'(i)}};
            @(negedge clk);
            chk("t1_rdv", o_avm_readdatavalid, 2'b01);
        end
        step();
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t1_active_end", o_active, 0);

        // 2: two ports contending, grants alternate
        do_reset();
        set_port(0, 32'h5000, 6'd2);
        set_port(1, 32'h6000, 6'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_grant", o_avm_waitrequest, t2_wait[i]);
            step();
        end
        i_avm_read = '0;
        for (int i = 0; i < 8; i++) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = {8{32'hB000_0000 + 32'(i)}};
            @(negedge clk);
            chk("t2_route", o_avm_readdatavalid, t2_rdv[i]);
            step();
        end
        avm_readdatavalid = 1'b0;

        // 3: grant held on port1 through waitrequest
        do_reset();
        avm_waitrequest = 1'b1;
        set_port(1, 32'h2000, 6'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_addr", avm_address, 32'h2000);
            chk("t3_hold_bc", avm_burstcount, 6'd3);
            chk("t3_hold_wait", o_avm_waitrequest, 2'b11);
            step();
            if (i == 0) set_port(0, 32'h3000, 6'd1);
        end
        avm_waitrequest = 1'b0;
        @(negedge clk);
        chk("t3_acc1", o_avm_waitrequest, 2'b01);
        step();
        i_avm_read[1] = 1'b0;
        @(negedge clk);
        chk("t3_acc0", o_avm_waitrequest, 2'b10);
        chk("t3_addr0", avm_address, 32'h3000);
        step();
        i_avm_read[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            avm_readdatavalid = 1'b1;
            @(negedge clk);
            chk("t3_route", o_avm_readdatavalid, t3_rdv[i]);
            step();
        end
        avm_readdatavalid = 1'b0;

        // 4: tracker full back-pressure
        do_reset();
        set_port(0, 32'h4000, 6'd1);
        for (int i = 0; i < MO; i++) begin
            @(negedge clk);
            chk("t4_fill", o_avm_waitrequest, 2'b10);
            step();
            i_avm_address[AW-1:0] = 32'h4000 + 32'(32 * (i + 1));
        end
        @(negedge clk);
        chk("t4_full_wait", o_avm_waitrequest, 2'b11);
        chk("t4_full_read", avm_read, 0);
        step();
        avm_readdatavalid = 1'b1;
        @(negedge clk);
        chk("t4_pop_wait", o_avm_waitrequest, 2'b11);
        chk("t4_pop_rdv", o_avm_readdatavalid, 2'b01);
        step();
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t4_after_pop", o_avm_waitrequest, 2'b10);
        step();
        i_avm_read = '0;
        avm_readdatavalid = 1'b1;
        for (int i = 0; i < MO; i++) step();
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t4_drained", o_active, 0);

        // 5: stray beat sets sticky error
        do_reset();
        avm_readdatavalid = 1'b1;
        @(negedge clk);
        chk("t5_no_rdv", o_avm_readdatavalid, 2'b00);
        step();
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t5_err", o_error, 1);
        step();
        step();
        @(negedge clk);
        chk("t5_err_sticky", o_error, 1);
        step();
        reset = 1'b1;
        #1;
        chk("t5_err_clr", o_error, 0);

        // 6: reset mid-burst
        do_reset();
        set_port(0, 32'h7000, 6'd4);
        @(negedge clk);
        chk("t6_acc", o_avm_waitrequest, 2'b10);
        step();
        i_avm_read = '0;
        avm_readdatavalid = 1'b1;
        step();
        step();
        set_port(0, 32'h7100, 6'd2);
        set_port(1, 32'h8100, 6'd2);
        reset = 1'b1;
        #1;
        chk("t6_rst_read", avm_read, 0);
        chk("t6_rst_rdv", o_avm_readdatavalid, 2'b00);
        chk("t6_rst_active", o_active, 0);
        chk("t6_rst_wait", o_avm_waitrequest, 2'b11);
        step();
        reset = 1'b0;
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        chk("t6_grant0", o_avm_waitrequest, 2'b10);
        chk("t6_addr0", avm_address, 32'h7100);
        step();
        i_avm_read = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
